axi_read_master: RTL and testbench
==================================

AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 ADDR_WIDTH, default 32, width of the target and AXI read address.
REQ-002 READ_CHANNEL_WIDTH, default 32, width of the R data and FIFO data.
REQ-003 READ_BURST_LEN, default 8, width of the burst-length field (value = beats-1).
REQ-004 cpu_clk  in  1  sole clock; all logic rising-edge.
REQ-005 cpu_rst  in  1  asynchronous, active-high reset.
REQ-006 axi_master_read_start  in  1  level request from the DMA; held high for several cycles by the requester.
REQ-007 axi_master_target_read_addr  in  ADDR_WIDTH  burst start address.
REQ-008 axi_master_target_read_burst_len  in  READ_BURST_LEN  beats-1.
REQ-009 axi_master_read_done  out  1  one-cycle completion pulse.
REQ-010 axi_master_read_err  out  1  error flag, valid while done is high.
REQ-011 master2dma_afifo_wpush  out  1  FIFO write strobe.
REQ-012 master2dma_afifo_wdata  out  READ_CHANNEL_WIDTH  FIFO write data.
REQ-013 master2dma_afifo_wfull  in  1  FIFO full.
REQ-014 m_araddr  out  ADDR_WIDTH  AR address.
REQ-015 m_arlen  out  8  AR length; burst_len zero-extended or truncated to 8 bits.
REQ-016 m_arvalid / m_arready  out / in  1 each  AR handshake (one REQ, paired signals).
REQ-017 m_rdata  in  READ_CHANNEL_WIDTH  R data.
REQ-018 m_rresp  in  2  R response; 2'b00 = OKAY.
REQ-019 m_rlast / m_rvalid / m_rready  in / in / out  1 each  R channel control.
REQ-020 Burst type is always INCR with full-width beats; size and burst are tied off in the interconnect wrapper and are not ports.

Function
REQ-021 The FSM SHALL have the states IDLE, ADDR, DATA, DONE and HOLD.
REQ-022 In IDLE with start=1, the block SHALL capture addr and len, clear the beat counter and the error flag, and enter ADDR; m_arvalid rises on the next cycle (latency 1).
REQ-023 In ADDR, m_arvalid=1 and m_araddr/m_arlen SHALL stay stable until m_arready=1; that handshake cycle moves the FSM to DATA.
REQ-024 In DATA, m_rready SHALL equal !master2dma_afifo_wfull.
  - m_rready is 0 in every other state.
REQ-025 A beat is accepted on m_rvalid && m_rready.
  - While beat count <= len: wpush=1 in the same cycle, wdata=m_rdata (combinational), count+1.
REQ-026 Beats accepted after len+1 beats without m_rlast SHALL be drained: not pushed, err set.
REQ-027 A beat with m_rresp != 0 SHALL set err; the beat is still pushed.
REQ-028 The accepted beat with m_rlast=1 SHALL end the burst and move the FSM to DONE.
  - err is also set if that beat is not beat number len+1.
REQ-029 The beat counter is READ_BURST_LEN+1 bits wide and saturates; it never wraps.
REQ-030 In DONE, axi_master_read_done=1 for exactly one cycle with axi_master_read_err valid, then the FSM moves to HOLD.
  - done asserts the cycle after the rlast beat.
REQ-031 HOLD SHALL remain until start=0, then return to IDLE; the same start level never triggers a second burst.
REQ-032 start changes in ADDR, DATA, DONE or HOLD SHALL be ignored; captured addr and len stay unchanged.
REQ-033 wpush SHALL never assert while wfull=1.
REQ-034 The block SHALL issue at most one outstanding AR at a time.

Reset
REQ-035 While cpu_rst=1, the following SHALL be 0 immediately (asynchronously): m_arvalid, m_rready, wpush, read_done, read_err, m_araddr, m_arlen and wdata; the state is IDLE and the counter is 0.
REQ-036 Reset mid-burst SHALL abandon the burst.
  - After release: no done pulse and no push; the FSM starts in IDLE and samples start on the first clock.

Verification
REQ-037 len=7, addr=0x1000, arready and rvalid always high -> AR 0x1000/len 7 once; 8 pushes in order; done 1 cycle after the rlast beat; err=0.
REQ-038 Same burst, wfull high during beats 3-5 -> rready=0 and no push in those cycles; all 8 words are pushed in order, none lost.
REQ-039 len=0 -> arlen=0; one beat with rlast is pushed; done pulses; err=0.
REQ-040 len=7 with rlast on beat 4 -> 4 pushes, done, err=1; separately, rresp=2'b10 on beat 2 -> 8 pushes, err=1.
REQ-041 start held high 10 cycles past done -> exactly one AR; drop start then raise it again -> a second AR.
REQ-042 cpu_rst pulsed during DATA -> arvalid/rready/wpush go 0 at once; after release, no done pulse until a new start.

Source files
------------

// File: rtl/axi_read_master_if.sv
// AXI4 read-address and read-data channel bundle between the read master and the interconnect.
// Burst type and beat size are fixed in the interconnect wrapper, so they do not appear here.
interface axi_read_master_if #(
    parameter int ADDR_WIDTH         = 32,
    parameter int READ_CHANNEL_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic [7:0]                    m_arlen;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [READ_CHANNEL_WIDTH-1:0] m_rdata;
    logic [1:0]                    m_rresp;
    logic                          m_rlast;
    logic                          m_rvalid;
    logic                          m_rready;

    modport master (
        output m_araddr,
        output m_arlen,
        output m_arvalid,
        input  m_arready,
        input  m_rdata,
        input  m_rresp,
        input  m_rlast,
        input  m_rvalid,
        output m_rready
    );

    modport slave (
        input  m_araddr,
        input  m_arlen,
        input  m_arvalid,
        output m_arready,
        output m_rdata,
        output m_rresp,
        output m_rlast,
        output m_rvalid,
        input  m_rready
    );
endinterface

// File: rtl/axi_read_master.sv
// Single-burst AXI read master: issues one INCR burst per DMA start level and streams the
// returned beats straight into the DMA FIFO, reporting completion and any error with a done pulse.
module axi_read_master #(
    parameter int ADDR_WIDTH         = 32,
    parameter int READ_CHANNEL_WIDTH = 32,
    parameter int READ_BURST_LEN     = 8
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst,
    input  logic                          axi_master_read_start,
    input  logic [ADDR_WIDTH-1:0]         axi_master_target_read_addr,
    input  logic [READ_BURST_LEN-1:0]     axi_master_target_read_burst_len,
    output logic                          axi_master_read_done,
    output logic                          axi_master_read_err,
    output logic                          master2dma_afifo_wpush,
    output logic [READ_CHANNEL_WIDTH-1:0] master2dma_afifo_wdata,
    input  logic                          master2dma_afifo_wfull,
    axi_read_master_if.master             m_axi
);

    localparam int CNT_W = READ_BURST_LEN + 1;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DONE,
        HOLD
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [READ_BURST_LEN-1:0] len_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      err_q;

    logic                      capture;
    logic                      beat_acc;
    logic                      beat_in_range;
    logic                      beat_err;
    logic [CNT_W-1:0]          len_ext;

    // One extra counter bit lets the count reach len+1 for the longest burst; it holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // AXI length field is 8 bits regardless of the local burst-length width.
    function automatic logic [7:0] to_arlen(input logic [READ_BURST_LEN-1:0] l);
        logic [READ_BURST_LEN+7:0] wide;
        wide = {8'd0, l};
        return wide[7:0];
    endfunction

    assign len_ext       = {1'b0, len_q};
    assign beat_in_range = (cnt_q <= len_ext);

    // Overrun beats, error responses and an rlast on the wrong beat all mark the burst bad.
    assign beat_err = (m_axi.m_rresp != RESP_OKAY)
                    || !beat_in_range
                    || (m_axi.m_rlast && (cnt_q != len_ext));

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt              = state;
        capture                = 1'b0;
        beat_acc               = 1'b0;
        m_axi.m_arvalid        = 1'b0;
        m_axi.m_rready         = 1'b0;
        master2dma_afifo_wpush = 1'b0;
        axi_master_read_done   = 1'b0;
        case (state)
            IDLE: begin
                if (axi_master_read_start) begin
                    capture   = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                m_axi.m_arvalid = 1'b1;
                if (m_axi.m_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                // Back-pressure from the FIFO goes straight onto the R channel.
                m_axi.m_rready         = !master2dma_afifo_wfull;
                beat_acc               = m_axi.m_rvalid && !master2dma_afifo_wfull;
                master2dma_afifo_wpush = beat_acc && beat_in_range;
                if (beat_acc && m_axi.m_rlast) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                axi_master_read_done = 1'b1;
                state_nxt            = HOLD;
            end
            HOLD: begin
                // Wait for the requester to drop start so one level yields one burst.
                if (!axi_master_read_start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (capture) begin
            addr_q <= axi_master_target_read_addr;
            len_q  <= axi_master_target_read_burst_len;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (beat_acc) begin
            cnt_q <= sat_inc(cnt_q);
            if (beat_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_axi.m_araddr         = addr_q;
    assign m_axi.m_arlen          = to_arlen(len_q);
    assign axi_master_read_err    = axi_master_read_done && err_q;
    assign master2dma_afifo_wdata = master2dma_afifo_wpush ? m_axi.m_rdata : '0;

    a_no_push_when_full : assert property (
        @(posedge cpu_clk) disable iff (cpu_rst)
        !(master2dma_afifo_wpush && master2dma_afifo_wfull)
    );

    a_ar_stable : assert property (
        @(posedge cpu_clk) disable iff (cpu_rst)
        (m_axi.m_arvalid && !m_axi.m_arready) |=>
            (m_axi.m_arvalid && $stable(m_axi.m_araddr) && $stable(m_axi.m_arlen))
    );

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: drives an AXI read slave and DMA FIFO from tasks, and a negedge
// monitor scores FIFO pushes, AR handshakes and done pulses against a queue of expected words.
module tb_axi_read_master;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        start;
    logic [31:0] target_addr;
    logic [7:0]  burst_len;
    logic        read_done;
    logic        read_err;
    logic        wpush;
    logic [31:0] wdata;
    logic        wfull;

    axi_read_master_if #(.ADDR_WIDTH(32), .READ_CHANNEL_WIDTH(32)) axi ();

    axi_read_master #(
        .ADDR_WIDTH(32),
        .READ_CHANNEL_WIDTH(32),
        .READ_BURST_LEN(8)
    ) dut (
        .cpu_clk                          (cpu_clk),
        .cpu_rst                          (cpu_rst),
        .axi_master_read_start            (start),
        .axi_master_target_read_addr      (target_addr),
        .axi_master_target_read_burst_len (burst_len),
        .axi_master_read_done             (read_done),
        .axi_master_read_err              (read_err),
        .master2dma_afifo_wpush           (wpush),
        .master2dma_afifo_wdata           (wdata),
        .master2dma_afifo_wfull           (wfull),
        .m_axi                            (axi)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int          total = 0;
    int          bad = 0;
    int          ncyc = 0;
    int          ar_cnt = 0;
    int          acc_cnt = 0;
    int          push_cnt = 0;
    int          done_cnt = 0;
    int          ar_cyc = 0;
    int          arv_rise_cyc = 0;
    int          last_cyc = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    logic        last_err = 1'b0;
    logic        prev_arvalid = 1'b0;
    logic [31:0] ar_addr_seen = '0;
    logic [7:0]  ar_len_seen = '0;
    logic [31:0] exp_araddr = '0;
    logic [7:0]  exp_arlen = '0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] beat_data(input logic [31:0] addr, input int b);
        return (32'hA500_0000 ^ addr) + (32'(b) * 32'h0001_0101);
    endfunction

    // Scoreboard monitor, sampled on the inactive edge.
    always @(negedge cpu_clk) begin
        logic [31:0] e;
        ncyc++;
        if (axi.m_arvalid === 1'b1) begin
            total++;
            if (axi.m_araddr !== exp_araddr || axi.m_arlen !== exp_arlen) begin
                bad++;
                $display("FAIL ar_stable: araddr=%h arlen=%0d required %h/%0d",
                         axi.m_araddr, axi.m_arlen, exp_araddr, exp_arlen);
            end
            if (prev_arvalid !== 1'b1) arv_rise_cyc = ncyc;
        end
        prev_arvalid = axi.m_arvalid;
        if (axi.m_arvalid === 1'b1 && axi.m_arready === 1'b1) begin
            ar_cnt++;
            ar_cyc       = ncyc;
            ar_addr_seen = axi.m_araddr;
            ar_len_seen  = axi.m_arlen;
        end
        if (wfull === 1'b1) begin
            total++;
            if (axi.m_rready !== 1'b0 || wpush !== 1'b0) begin
                bad++;
                $display("FAIL full_stall: rready=%b wpush=%b required 0/0", axi.m_rready, wpush);
            end
        end
        if (axi.m_rvalid === 1'b1 && axi.m_rready === 1'b1) begin
            acc_cnt++;
            if (axi.m_rlast === 1'b1) last_cyc = ncyc;
        end
        if (wpush === 1'b1) begin
            push_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL push_unexpected: got %h required no push", wdata);
            end else begin
                e = exp_q.pop_front();
                if (wdata !== e) begin
                    bad++;
                    $display("FAIL push_data: got %h required %h", wdata, e);
                end
            end
        end
        if (read_done === 1'b1) begin
            done_cnt++;
            done_cyc = ncyc;
            last_err = read_err;
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_inputs();
        axi.m_rvalid = 1'b0;
        axi.m_rlast  = 1'b0;
        axi.m_rresp  = 2'b00;
        axi.m_rdata  = '0;
        wfull        = 1'b0;
    endtask

    // Plays one burst as the slave. last_at = index of the rlast beat, bad_at = index given SLVERR,
    // full_at = index at which the FIFO reports full for 3 cycles, abort_at returns mid-burst.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int last_at,
                             input int bad_at, input int full_at, input int ar_wait,
                             input int hold_cyc, input int abort_at, output bit timed_out);
        int ar0, acc0, d0, b, cyc, full_left, w;
        ar0 = ar_cnt; acc0 = acc_cnt; d0 = done_cnt;
        full_left = 3; w = ar_wait; cyc = 0; timed_out = 1'b0;
        for (int i = 0; i <= last_at && i <= int'(len); i++) exp_q.push_back(beat_data(addr, i));
        exp_araddr = addr; exp_arlen = len;
        start_cyc = ncyc;
        target_addr = addr; burst_len = len; start = 1'b1;
        axi.m_arready = (w == 0);
        while (done_cnt == d0) begin
            if (cyc >= 200) begin
                timed_out = 1'b1;
                exp_q.delete();
                break;
            end
            tick();
            cyc++;
            if (cyc == 1) begin
                target_addr = ~addr;
                burst_len   = ~len;
            end
            if (w > 0) w--;
            axi.m_arready = (w == 0);
            b = acc_cnt - acc0;
            if (abort_at >= 0 && b >= abort_at) return;
            if (ar_cnt != ar0 && b <= last_at) begin
                axi.m_rvalid = 1'b1;
                axi.m_rdata  = beat_data(addr, b);
                axi.m_rlast  = (b == last_at);
                axi.m_rresp  = (b == bad_at) ? 2'b10 : 2'b00;
            end else begin
                idle_inputs();
            end
            if (ar_cnt != ar0 && b == full_at && full_left > 0) begin
                wfull = 1'b1;
                full_left--;
            end else begin
                wfull = 1'b0;
            end
        end
        idle_inputs();
        repeat (hold_cyc) tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        start = 1'b0; target_addr = 32'hDEAD_BEEF; burst_len = 8'hFF;
        axi.m_arready = 1'b1;
        idle_inputs();
        cpu_rst = 1'b0;
        #1 cpu_rst = 1'b1;
        #12;
        total++;
        if ({axi.m_arvalid, axi.m_rready, wpush, read_done, read_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: arvalid,rready,wpush,done,err=%b required 00000",
                     {axi.m_arvalid, axi.m_rready, wpush, read_done, read_err});
        end
        total++;
        if ({axi.m_araddr, axi.m_arlen, wdata} !== 72'b0) begin
            bad++;
            $display("FAIL reset_data: araddr=%h arlen=%h wdata=%h required 0",
                     axi.m_araddr, axi.m_arlen, wdata);
        end
        tick();
        cpu_rst = 1'b0;
        tick();
        tick();
        total++;
        if (axi.m_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: arvalid=%b required 0 without start", axi.m_arvalid);
        end
    endtask

    task automatic test_basic();
        int ar0, p0, d0;
        bit to;
        ar0 = ar_cnt; p0 = push_cnt; d0 = done_cnt;
        run_burst(32'h1000, 8'd7, 7, -1, -1, 0, 0, -1, to);
        total++;
        if (to) begin bad++; $display("FAIL basic_timeout: no done within 200 cycles"); end
        total++;
        if (ar_cnt - ar0 != 1 || ar_addr_seen !== 32'h1000 || ar_len_seen !== 8'd7) begin
            bad++;
            $display("FAIL basic_ar: count=%0d addr=%h len=%0d required 1/00001000/7",
                     ar_cnt - ar0, ar_addr_seen, ar_len_seen);
        end
        total++;
        if (arv_rise_cyc - start_cyc != 2) begin
            bad++;
            $display("FAIL basic_ar_latency: arvalid at +%0d cycles required +2", arv_rise_cyc - start_cyc);
        end
        total++;
        if (push_cnt - p0 != 8 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_pushes: got %0d left %0d required 8/0", push_cnt - p0, exp_q.size());
        end
        total++;
        if (done_cyc - last_cyc != 1 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL basic_done: delay=%0d pulses=%0d required 1/1", done_cyc - last_cyc, done_cnt - d0);
        end
        total++;
        if (last_err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b required 0", last_err); end
    endtask

    task automatic test_backpressure();
        int p0;
        bit to;
        p0 = push_cnt;
        run_burst(32'h1100, 8'd7, 7, -1, 2, 0, 0, -1, to);
        total++;
        if (to || push_cnt - p0 != 8 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_pushes: got %0d left %0d timeout=%b required 8/0/0", push_cnt - p0, exp_q.size(), to);
        end
        total++;
        if (last_err !== 1'b0) begin bad++; $display("FAIL bp_err: got %b required 0", last_err); end
    endtask

    task automatic test_len0();
        int p0;
        bit to;
        p0 = push_cnt;
        run_burst(32'h0000_2000, 8'd0, 0, -1, -1, 0, 0, -1, to);
        total++;
        if (ar_len_seen !== 8'd0) begin bad++; $display("FAIL len0_arlen: got %0d required 0", ar_len_seen); end
        total++;
        if (to || push_cnt - p0 != 1 || done_cyc - last_cyc != 1 || last_err !== 1'b0) begin
            bad++;
            $display("FAIL len0_burst: pushes=%0d delay=%0d err=%b required 1/1/0",
                     push_cnt - p0, done_cyc - last_cyc, last_err);
        end
    endtask

    task automatic test_errors();
        int p0;
        bit to;
        p0 = push_cnt;
        run_burst(32'h3000, 8'd7, 3, -1, -1, 0, 0, -1, to);
        total++;
        if (to || push_cnt - p0 != 4 || last_err !== 1'b1) begin
            bad++;
            $display("FAIL early_last: pushes=%0d err=%b required 4/1", push_cnt - p0, last_err);
        end
        p0 = push_cnt;
        run_burst(32'h3100, 8'd7, 7, 1, -1, 0, 0, -1, to);
        total++;
        if (to || push_cnt - p0 != 8 || last_err !== 1'b1) begin
            bad++;
            $display("FAIL bad_resp: pushes=%0d err=%b required 8/1", push_cnt - p0, last_err);
        end
        p0 = push_cnt;
        run_burst(32'h3200, 8'd1, 3, -1, -1, 0, 0, -1, to);
        total++;
        if (to || push_cnt - p0 != 2 || last_err !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL overrun_drain: pushes=%0d err=%b required 2/1", push_cnt - p0, last_err);
        end
    endtask

    task automatic test_back_to_back();
        int ar0, d0;
        bit to;
        ar0 = ar_cnt; d0 = done_cnt;
        run_burst(32'h4000, 8'd3, 3, -1, -1, 2, 10, -1, to);
        total++;
        if (to || ar_cnt - ar0 != 1 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL start_held: ars=%0d dones=%0d required 1/1", ar_cnt - ar0, done_cnt - d0);
        end
        run_burst(32'h4040, 8'd3, 3, -1, -1, 0, 0, -1, to);
        total++;
        if (to || ar_cnt - ar0 != 2 || ar_addr_seen !== 32'h4040 || last_err !== 1'b0) begin
            bad++;
            $display("FAIL restart: ars=%0d addr=%h err=%b required 2/00004040/0",
                     ar_cnt - ar0, ar_addr_seen, last_err);
        end
    endtask

    task automatic test_reset_mid();
        int p0, d0;
        bit to;
        run_burst(32'h5000, 8'd7, 7, -1, -1, 0, 0, 3, to);
        #2;
        total++;
        if (axi.m_rready !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: rready=%b required 1 before reset", axi.m_rready);
        end
        cpu_rst = 1'b1;
        #1;
        total++;
        if ({axi.m_arvalid, axi.m_rready, wpush} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset: arvalid,rready,wpush=%b required 000", {axi.m_arvalid, axi.m_rready, wpush});
        end
        exp_q.delete();
        p0 = push_cnt; d0 = done_cnt;
        start = 1'b0;
        idle_inputs();
        tick();
        tick();
        cpu_rst = 1'b0;
        repeat (10) tick();
        total++;
        if (push_cnt != p0 || done_cnt != d0) begin
            bad++;
            $display("FAIL mid_after: pushes=%0d dones=%0d required 0/0", push_cnt - p0, done_cnt - d0);
        end
        p0 = push_cnt;
        run_burst(32'h5100, 8'd2, 2, -1, -1, 0, 0, -1, to);
        total++;
        if (to || push_cnt - p0 != 3 || done_cnt - d0 != 1 || last_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_recover: pushes=%0d dones=%0d err=%b required 3/1/0",
                     push_cnt - p0, done_cnt - d0, last_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
